// File: rtl/pll_clock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_clock_supervisor
// Brief    : iCE40 PLL reset/lock supervisor. Releases a downstream reset once
//            lock is stable and generates per-channel divided clock enables.
// Revision : 1.0 - initial release
// ============================================================================
module pll_clock_supervisor #(
  parameter int                    N_CH          = 2,
  parameter int                    DIV_W         = 16,
  parameter logic [N_CH*DIV_W-1:0] DIV_LIST      = {16'd96, 16'd2},
  parameter int                    SYNC_STAGES   = 2,
  parameter int                    RST_HOLD      = 16,
  parameter int                    STABLE_CYCLES = 1024,
  parameter int                    LOCK_TIMEOUT  = 65535,
  parameter int                    LOSS_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pll_lock,
  output logic              pll_resetb,
  output logic              sys_reset,
  output logic              ready,
  output logic [N_CH-1:0]   clk_en,
  output logic [LOSS_W-1:0] loss_count,
  output logic [2:0]        state
);

  localparam logic [2:0] c_st_pll_rst   = 3'd0;
  localparam logic [2:0] c_st_wait_lock = 3'd1;
  localparam logic [2:0] c_st_stabilise = 3'd2;
  localparam logic [2:0] c_st_run       = 3'd3;
  localparam logic [2:0] c_st_lost      = 3'd4;

  localparam int c_max_a   = (RST_HOLD > STABLE_CYCLES) ? RST_HOLD : STABLE_CYCLES;
  localparam int c_cnt_max = (c_max_a > LOCK_TIMEOUT) ? c_max_a : LOCK_TIMEOUT;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RST_HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last  = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_stab_last = c_cnt_w'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic [2:0]             r_state;
  logic [2:0]             w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   w_resetb_nxt;
  logic                   w_run_nxt;
  logic                   w_loss_inc;
  logic [N_CH-1:0]        w_strobe;
  logic                   r_pll_resetb;
  logic                   r_sys_reset;
  logic                   r_ready;
  logic [N_CH-1:0]        r_clk_en;
  logic [LOSS_W-1:0]      r_loss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_pll_rst;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ENABLE low overrides every transition, including a coincident lock loss.
  always_comb begin
    w_state_nxt = c_st_pll_rst;
    if (enable) begin
      case (r_state)
        c_st_pll_rst: begin
          w_state_nxt = (r_cnt == c_hold_last) ? c_st_wait_lock : c_st_pll_rst;
        end
        c_st_wait_lock: begin
          if (w_lock_s) begin
            w_state_nxt = c_st_stabilise;
          end else if (r_cnt == c_tmo_last) begin
            w_state_nxt = c_st_pll_rst;
          end else begin
            w_state_nxt = c_st_wait_lock;
          end
        end
        c_st_stabilise: begin
          if (!w_lock_s) begin
            w_state_nxt = c_st_wait_lock;
          end else if (r_cnt == c_stab_last) begin
            w_state_nxt = c_st_run;
          end else begin
            w_state_nxt = c_st_stabilise;
          end
        end
        c_st_run: begin
          w_state_nxt = w_lock_s ? c_st_run : c_st_lost;
        end
        default: begin
          w_state_nxt = c_st_pll_rst;
        end
      endcase
    end
  end

  // One shared phase counter; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || (w_state_nxt != r_state)) begin
      r_cnt <= '0;
    end else if ((r_state == c_st_pll_rst) || (r_state == c_st_wait_lock) ||
                 (r_state == c_st_stabilise)) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  always_comb begin
    w_resetb_nxt = 1'b1;
    w_run_nxt    = 1'b0;
    w_loss_inc   = 1'b0;
    case (w_state_nxt)
      c_st_pll_rst: w_resetb_nxt = 1'b0;
      c_st_run:     w_run_nxt    = 1'b1;
      c_st_lost:    w_loss_inc   = 1'b1;
      default:      w_resetb_nxt = 1'b1;
    endcase
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_div
    localparam logic [DIV_W-1:0] c_div  = DIV_LIST[gi*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] c_last = (c_div > DIV_W'(1)) ? (c_div - DIV_W'(1)) : '0;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;

    // Counter is zero on the RUN-entry edge so all channels start phase-aligned.
    always_comb begin
      w_div_nxt = '0;
      if (w_run_nxt && (r_state == c_st_run) && (r_div != c_last)) begin
        w_div_nxt = r_div + DIV_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div <= '0;
      end else begin
        r_div <= w_div_nxt;
      end
    end

    assign w_strobe[gi] = w_run_nxt && (w_div_nxt == c_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_resetb <= 1'b0;
      r_sys_reset  <= 1'b0;
      r_ready      <= 1'b0;
      r_clk_en     <= '0;
      r_loss       <= '0;
    end else begin
      r_pll_resetb <= w_resetb_nxt;
      r_sys_reset  <= w_run_nxt;
      r_ready      <= w_run_nxt;
      r_clk_en     <= w_strobe;
      if (w_loss_inc && (r_loss != {LOSS_W{1'b1}})) begin
        r_loss <= r_loss + LOSS_W'(1);
      end
    end
  end

  assign pll_resetb = r_pll_resetb;
  assign sys_reset  = r_sys_reset;
  assign ready      = r_ready;
  assign clk_en     = r_clk_en;
  assign loss_count = r_loss;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_clock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_clock_supervisor
// Brief    : Self-checking bench for pll_clock_supervisor (vectors + model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_clock_supervisor;

  localparam int N_CH     = 3;
  localparam int SYNC     = 2;
  localparam int RST_HOLD = 4;
  localparam int STABLE   = 8;
  localparam int TMO      = 20;
  localparam int LOSS_MAX = 255;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            enable   = 1'b1;
  logic            pll_lock = 1'b1;
  logic            pll_resetb;
  logic            sys_reset;
  logic            ready;
  logic [N_CH-1:0] clk_en;
  logic [7:0]      loss_count;
  logic [2:0]      state;

  int n_cmp = 0;
  int n_err = 0;
  int c_div [N_CH] = '{1, 3, 0};

  // Reference model: phase number, cycles spent in it, RUN cycle index.
  int m_state = 0;
  int m_timer = 0;
  int m_run   = 0;
  int m_loss  = 0;
  bit m_ls;
  bit m_lockq[$];

  typedef struct {
    logic            en;
    logic            lock;
    int              reps;
    int              st;
    logic            rb;
    logic            rdy;
    logic [N_CH-1:0] cen;
  } vec_t;
  vec_t tbl [10];

  pll_clock_supervisor #(
    .N_CH          (N_CH),
    .DIV_W         (16),
    .DIV_LIST      ({16'd0, 16'd3, 16'd1}),
    .SYNC_STAGES   (SYNC),
    .RST_HOLD      (RST_HOLD),
    .STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT  (TMO),
    .LOSS_W        (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pll_lock   (pll_lock),
    .pll_resetb (pll_resetb),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .clk_en     (clk_en),
    .loss_count (loss_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (!rst_n) begin
      m_state = 0; m_timer = 0; m_run = 0; m_loss = 0;
      m_lockq.delete();
    end else begin
      m_ls = (m_lockq.size() == SYNC) ? m_lockq.pop_front() : 1'b0;
      m_lockq.push_back(pll_lock);
      if (!enable) begin
        m_state = 0; m_timer = 0;
      end else begin
        case (m_state)
          0: begin
            m_timer = m_timer + 1;
            if (m_timer == RST_HOLD) begin m_state = 1; m_timer = 0; end
          end
          1: begin
            if (m_ls) begin m_state = 2; m_timer = 0; end
            else begin
              m_timer = m_timer + 1;
              if (m_timer == TMO) begin m_state = 0; m_timer = 0; end
            end
          end
          2: begin
            if (!m_ls) begin m_state = 1; m_timer = 0; end
            else begin
              m_timer = m_timer + 1;
              if (m_timer == STABLE) begin m_state = 3; m_timer = 0; end
            end
          end
          3: begin
            if (!m_ls) begin
              m_state = 4;
              if (m_loss < LOSS_MAX) m_loss = m_loss + 1;
            end
          end
          default: begin m_state = 0; m_timer = 0; end
        endcase
      end
      m_run = (m_state == 3) ? m_run + 1 : 0;
    end
  endtask

  function automatic logic [N_CH-1:0] m_clk_en();
    logic [N_CH-1:0] e;
    e = '0;
    for (int i = 0; i < N_CH; i++)
      if (m_state == 3 && (c_div[i] <= 1 || (m_run % c_div[i]) == 0)) e[i] = 1'b1;
    return e;
  endfunction

  // Advance one clock, update the model for that edge, compare every output.
  task automatic tick();
    logic [16:0] got;
    logic [16:0] exp;
    @(negedge clk);
    model_step();
    got = {state, pll_resetb, sys_reset, ready, clk_en, loss_count};
    exp = {3'(m_state), m_state != 0, m_state == 3, m_state == 3, m_clk_en(), 8'(m_loss)};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL model t=%0t {st,rb,sr,rdy,cen,loss} got=%h exp=%h", $time, got, exp);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (int'(state) != st && n < budget);
    check(name, int'(state), st);
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        enable   = tbl[r].en;
        pll_lock = tbl[r].lock;
        tick();
        check($sformatf("%s_vec%0d", tag, r),
              int'({state, pll_resetb, sys_reset, ready, clk_en}),
              int'({3'(tbl[r].st), tbl[r].rb, tbl[r].rdy, tbl[r].rdy, tbl[r].cen}));
      end
    end
  endtask

  initial begin
    int f1, f2, f3, nf, cnt;
    logic prev_rb, rdy_seen;

    // Start-up with lock high from t0: 4 cycles PLL reset, 8 stable cycles, then RUN.
    tbl[0] = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 1'b1, 1, 1, 1'b1, 1'b0, 3'b000};
    tbl[2] = '{1'b1, 1'b1, 8, 2, 1'b1, 1'b0, 3'b000};
    tbl[3] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b101};
    tbl[4] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b101};
    tbl[5] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b111};
    tbl[6] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b101};
    tbl[7] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b101};
    tbl[8] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b111};
    tbl[9] = '{1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 3'b101};

    #1;
    check("reset_outputs", int'({state, pll_resetb, sys_reset, ready, clk_en}), 0);
    check("reset_loss", int'(loss_count), 0);
    tick();
    #2 rst_n = 1'b1;
    run_table("startup");

    // Lock loss in RUN
    pll_lock = 1'b0;
    wait_state(4, 6, "lost_enter");
    check("lost_loss", int'(loss_count), 1);
    check("lost_outs", int'({sys_reset, ready, clk_en}), 0);
    tick();
    check("lost_to_rst", int'({state, pll_resetb}), 0);
    pll_lock = 1'b1;
    wait_state(3, 40, "relock_run");

    // ENABLE drop coincident with the synchronised lock drop
    pll_lock = 1'b0;
    tick();
    tick();
    check("en_still_run", int'(state), 3);
    enable = 1'b0;
    tick();
    check("en_to_rst", int'(state), 0);
    check("en_loss_kept", int'(loss_count), 1);
    check("en_sysrst", int'(sys_reset), 0);

    // One-cycle lock glitch at stabilise count 5
    enable   = 1'b1;
    pll_lock = 1'b1;
    wait_state(2, 60, "glitch_stab");
    tick(); tick(); tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_state(1, 6, "glitch_back_wait");
    wait_state(2, 4, "glitch_restab");
    cnt = 0;
    while (state != 3'd3 && cnt < 40) begin tick(); cnt++; end
    check("glitch_stable_len", cnt, 8);

    // Lock never returns: PLL reset re-pulses every RST_HOLD + TMO cycles
    pll_lock = 1'b0;
    nf = 0; cnt = 0; f1 = 0; f2 = 0; f3 = 0; rdy_seen = 1'b0;
    prev_rb = pll_resetb;
    while (nf < 3 && cnt < 200) begin
      tick();
      cnt++;
      if (prev_rb && !pll_resetb) begin
        nf++;
        if (nf == 1) f1 = cnt; else if (nf == 2) f2 = cnt; else f3 = cnt;
      end
      if (nf >= 1 && ready) rdy_seen = 1'b1;
      prev_rb = pll_resetb;
    end
    check("tmo_falls", nf, 3);
    check("tmo_period1", f2 - f1, RST_HOLD + TMO);
    check("tmo_period2", f3 - f2, RST_HOLD + TMO);
    check("tmo_ready_low", int'(rdy_seen), 0);

    // Asynchronous reset in the middle of STABILISE
    pll_lock = 1'b1;
    wait_state(2, 60, "arst_stab");
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", int'({state, pll_resetb, sys_reset, ready, clk_en}), 0);
    check("arst_loss", int'(loss_count), 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    run_table("restart");

    // Random lock / enable activity against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 4) pll_lock = ~pll_lock;
      if (enable) enable = ($urandom_range(0, 149) != 0);
      else        enable = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Repeated loss events: counter must saturate
    for (int it = 0; it < 300; it++) begin
      enable   = 1'b1;
      pll_lock = 1'b1;
      wait_state(3, 100, "sat_run");
      repeat ($urandom_range(0, 3)) tick();
      pll_lock = 1'b0;
      wait_state(4, 10, "sat_lost");
    end
    check("loss_saturated", int'(loss_count), LOSS_MAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
